gpio_event_capture: RTL and testbench
=====================================

// Module: gpio_event_capture
// PURPOSE
//   Parametrised, memory-mapped input-capture block for N_CH debounced inputs (keys/switches).
//   Each channel runs a 2-flop synchroniser, a per-channel debounce counter and an edge detector.
//   Edge detection is selectable per channel: rising, falling or both.
//   Events latch into a sticky, write-1-to-clear status register with a per-channel interrupt mask.
//   Sits on the CPU peripheral bus (CS_N/RD_N/WR_N, 12-bit offset) beside the LED/HEX output registers.
// PARAMETERS
//   N_CH             18   number of input channels, 1..32
//   DEBOUNCE_CYCLES  16   consecutive differing samples needed to accept a new level, >=2
//   INIT_LEVEL       1'b1 level loaded into synchronisers and debounced state at reset (all channels)
//   (derived) CNT_W = $clog2(DEBOUNCE_CYCLES)
// PORTS
//   CLOCK_50   in   1      system clock; all flops on posedge
//   reset      in   1      asynchronous, active-high reset
//   CS_N       in   1      chip select, active low
//   RD_N       in   1      read strobe, active low
//   WR_N       in   1      write strobe, active low
//   Addr       in   12     byte offset, word aligned
//   DataIn     in   32     write data
//   pin_in     in   N_CH   raw asynchronous inputs
//   DataOut    out  32     read data, combinational; 0 when not reading
//   level_out  out  N_CH   debounced levels
//   Intr       out  1      active-low interrupt: ~|(STATUS & IMASK)
// BEHAVIOUR
//   Register map (bits >= N_CH read 0 and ignore writes):
//     0x000 LEVEL   RO   debounced levels
//     0x004 STATUS  W1C  sticky event flags; reads have no side effect
//     0x008 IMASK   RW   interrupt enable per channel, reset 0
//     0x00C RISE_EN RW   capture rising edges, reset all 1
//     0x010 FALL_EN RW   capture falling edges, reset all 0
//     Other offsets: read 0, writes ignored. Writes to LEVEL are ignored.
//   Reset (async, any time, including mid-debounce):
//     - sync flops and level = INIT_LEVEL; counters = 0; STATUS = 0.
//     - Intr = 1 (deasserted).
//     - No event is generated on reset release.
//   Debounce, per channel. s = second sync flop, L = debounced level.
//     - s == L: counter <= 0.
//     - s != L and counter < DEBOUNCE_CYCLES-1: counter++.
//     - s != L and counter == DEBOUNCE_CYCLES-1: L <= s, counter <= 0, event fires on the same edge.
//     - Latency: pin_in first sampled at edge k and held -> L and STATUS change at edge k+DEBOUNCE_CYCLES+1.
//     - A glitch shorter than DEBOUNCE_CYCLES samples produces no level change and no event.
//   Event: STATUS[i] <= 1 when L rises and RISE_EN[i]=1, or when L falls and FALL_EN[i]=1.
//   Bus write: occurs on the posedge when ~CS_N & ~WR_N.
//     - STATUS: bits written 1 clear; bits written 0 are unchanged.
//     - A new event and a W1C clear of the same bit on the same edge: set wins (bit stays 1).
//   Bus read: DataOut = register when ~CS_N & ~RD_N, else 32'b0.
//     - If RD and WR are both active, the read returns pre-write values.
//   Intr is combinational from STATUS and IMASK.
//     - Unmasking an already-set bit asserts Intr on the edge after the IMASK write.
//   Channels are fully independent; multiple channels may fire on the same edge.
// TESTING
//   1. D=4, INIT_LEVEL=1, pin0 1->0 sampled at edge 10, FALL_EN[0]=1
//      -> level_out[0]=0 and STATUS=0x1 at edge 15; Intr stays 1 while IMASK=0.
//   2. D=4, pin3 low for 3 samples then high
//      -> LEVEL, STATUS and Intr unchanged throughout.
//   3. IMASK=0x1 with STATUS[0]=1 -> Intr=0.
//      Then write 0x1 to 0x004 -> STATUS=0, Intr=1 on the next edge.
//      Then write 0x0 to 0x004 -> no change.
//   4. Event on ch2 coincides with a W1C of 0x4 on the same edge -> STATUS[2]=1 afterwards.
//      Also: RISE_EN=FALL_EN=1 and a full press/release -> two events captured.
//   5. Assert reset mid-count (counter=2), release it
//      -> LEVEL=INIT_LEVEL, STATUS=0, Intr=1, no spurious event within 2*D cycles.
//   6. N_CH=4: read 0x000/0x004 -> bits[31:4]=0.
//      Read 0x100 -> 0. DataOut=0 while RD_N=1.

Source files
------------

// File: rtl/gpio_event_capture.sv
// gpio_event_capture: debounced, edge-qualified input capture for keys/switches.
// Sticky W1C status, per-channel edge select and interrupt mask on the CPU bus.

module gpio_debounce_ch #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INIT_LEVEL      = 1'b1
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             s;
   logic             flip;

   assign s    = sync_q[1];
   assign flip = (s != level_q) && (cnt_q == CNT_MAX);

   // Two-flop synchroniser for the raw asynchronous pin
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync_q <= {2{INIT_LEVEL}};
      end else begin
         sync_q <= {sync_q[0], pin};
      end
   end

   // Accept a new level only after it persists for the full debounce window
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= INIT_LEVEL;
      end else if (s == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
         level_q <= s;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = level_q;
   assign rise  = flip & s;
   assign fall  = flip & ~s;

endmodule

module gpio_event_capture #(
   parameter int   N_CH            = 18,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INIT_LEVEL      = 1'b1
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            CS_N,
   input  logic            RD_N,
   input  logic            WR_N,
   input  logic [11:0]     Addr,
   input  logic [31:0]     DataIn,
   input  logic [N_CH-1:0] pin_in,
   output logic [31:0]     DataOut,
   output logic [N_CH-1:0] level_out,
   output logic            Intr
);

   localparam logic [11:0] ADDR_LEVEL   = 12'h000;
   localparam logic [11:0] ADDR_STATUS  = 12'h004;
   localparam logic [11:0] ADDR_IMASK   = 12'h008;
   localparam logic [11:0] ADDR_RISE_EN = 12'h00C;
   localparam logic [11:0] ADDR_FALL_EN = 12'h010;

   logic            wr_en;
   logic            rd_en;
   logic [N_CH-1:0] wr_data;
   logic [N_CH-1:0] rise_ev;
   logic [N_CH-1:0] fall_ev;
   logic [N_CH-1:0] event_set;
   logic [N_CH-1:0] status_clr;
   logic [N_CH-1:0] status_q;
   logic [N_CH-1:0] imask_q;
   logic [N_CH-1:0] rise_en_q;
   logic [N_CH-1:0] fall_en_q;
   logic [31:0]     rd_data;

   assign wr_en   = ~CS_N & ~WR_N;
   assign rd_en   = ~CS_N & ~RD_N;
   assign wr_data = DataIn[N_CH-1:0];

   generate
      if (N_CH < 32) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^DataIn[31:N_CH];
      end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         gpio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_LEVEL     (INIT_LEVEL)
         ) u_ch (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .pin     (pin_in[i]),
            .level   (level_out[i]),
            .rise    (rise_ev[i]),
            .fall    (fall_ev[i])
         );
      end
   endgenerate

   assign event_set  = (rise_ev & rise_en_q) | (fall_ev & fall_en_q);
   assign status_clr = (wr_en && (Addr == ADDR_STATUS)) ? wr_data : '0;

   // Sticky flags: clear first, then OR new events so a coincident set wins
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         status_q <= '0;
      end else begin
         status_q <= (status_q & ~status_clr) | event_set;
      end
   end

   // Software-owned control registers
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         imask_q   <= '0;
         rise_en_q <= '1;
         fall_en_q <= '0;
      end else if (wr_en) begin
         case (Addr)
            ADDR_IMASK:   imask_q   <= wr_data;
            ADDR_RISE_EN: rise_en_q <= wr_data;
            ADDR_FALL_EN: fall_en_q <= wr_data;
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] zext(input logic [N_CH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[N_CH-1:0] = v;
      return r;
   endfunction

   // Read mux sees pre-edge register values; idle bus drives zero
   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (Addr)
            ADDR_LEVEL:   rd_data = zext(level_out);
            ADDR_STATUS:  rd_data = zext(status_q);
            ADDR_IMASK:   rd_data = zext(imask_q);
            ADDR_RISE_EN: rd_data = zext(rise_en_q);
            ADDR_FALL_EN: rd_data = zext(fall_en_q);
            default:      rd_data = '0;
         endcase
      end
   end

   assign DataOut = rd_data;
   assign Intr    = ~|(status_q & imask_q);

endmodule

// File: tb/tb_gpio_event_capture.sv
// tb_gpio_event_capture: directed and random checks of gpio_event_capture
// against a sample-window reference model.

module tb_gpio_event_capture;

   localparam int N = 4;
   localparam int D = 4;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic          CS_N, RD_N, WR_N;
   logic [11:0]   Addr;
   logic [31:0]   DataIn;
   logic [N-1:0]  pin_in;
   logic [31:0]   DataOut;
   logic [N-1:0]  level_out;
   logic          Intr;

   gpio_event_capture #(
      .N_CH           (N),
      .DEBOUNCE_CYCLES(D),
      .INIT_LEVEL     (1'b1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .CS_N     (CS_N),
      .RD_N     (RD_N),
      .WR_N     (WR_N),
      .Addr     (Addr),
      .DataIn   (DataIn),
      .pin_in   (pin_in),
      .DataOut  (DataOut),
      .level_out(level_out),
      .Intr     (Intr)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   // Reference state: levels change when the last D synchronised samples
   // (pin samples from 2..D+1 edges ago) all disagree with the current level.
   logic [N-1:0] m_lvl, m_st, m_im, m_re, m_fe;
   logic [D+1:0] m_hist [N];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         12'h000: r[N-1:0] = m_lvl;
         12'h004: r[N-1:0] = m_st;
         12'h008: r[N-1:0] = m_im;
         12'h00C: r[N-1:0] = m_re;
         12'h010: r[N-1:0] = m_fe;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_lvl = '1;
      m_st  = '0;
      m_im  = '0;
      m_re  = '1;
      m_fe  = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '1;
   endtask

   task automatic model_edge();
      logic [N-1:0] ev, nl, clr;
      logic         wr;
      ev = '0;
      nl = m_lvl;
      for (int i = 0; i < N; i++) begin
         m_hist[i] = {m_hist[i][D:0], pin_in[i]};
         if (m_hist[i][D+1:2] == {D{~m_lvl[i]}}) begin
            nl[i] = ~m_lvl[i];
            ev[i] = nl[i] ? m_re[i] : m_fe[i];
         end
      end
      wr  = !CS_N && !WR_N;
      clr = (wr && Addr == 12'h004) ? DataIn[N-1:0] : '0;
      m_st = (m_st & ~clr) | ev;
      if (wr && Addr == 12'h008) m_im = DataIn[N-1:0];
      if (wr && Addr == 12'h00C) m_re = DataIn[N-1:0];
      if (wr && Addr == 12'h010) m_fe = DataIn[N-1:0];
      m_lvl = nl;
   endtask

   task automatic bus_idle();
      CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
      Addr = '0;   DataIn = '0;
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      chk("level", 32'(level_out), 32'(m_lvl));
      chk("intr", 32'(Intr), 32'(~|(m_st & m_im)));
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      CS_N = 1'b0; RD_N = 1'b1; WR_N = 1'b0;
      Addr = a;    DataIn = d;
      tick();
      bus_idle();
   endtask

   task automatic rdc(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
      CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1;
      Addr = a;
      #1;
      chk(tag, DataOut, exp);
      chk({tag, "_model"}, DataOut, m_read(a));
      bus_idle();
      tick();
   endtask

   initial begin
      logic [11:0] addrs [7];
      logic [11:0] a;
      logic [31:0] d;
      int          op;
      int          hold [N];

      addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                12'h014, 12'h100};

      reset  = 1'b1;
      pin_in = '1;
      bus_idle();
      model_reset();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      #1;
      chk("rst_level", 32'(level_out), 32'hF);
      chk("rst_intr", 32'(Intr), 32'h1);
      rdc("rst_status", 12'h004, 32'h0);
      rdc("rst_imask", 12'h008, 32'h0);
      rdc("rst_rise", 12'h00C, 32'hF);
      rdc("rst_fall", 12'h010, 32'h0);

      // falling edge on ch0 with FALL_EN[0]
      wr(12'h010, 32'h1);
      pin_in[0] = 1'b0;
      for (int j = 0; j < D + 1; j++) begin
         tick();
         chk("t1_hold", 32'(level_out[0]), 32'h1);
      end
      tick();
      chk("t1_level", 32'(level_out[0]), 32'h0);
      chk("t1_intr", 32'(Intr), 32'h1);
      rdc("t1_status", 12'h004, 32'h1);

      // glitch on ch3 shorter than the window
      pin_in[3] = 1'b0;
      for (int j = 0; j < 3; j++) tick();
      pin_in[3] = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         chk("t2_level", 32'(level_out), 32'hE);
         chk("t2_intr", 32'(Intr), 32'h1);
      end
      rdc("t2_status", 12'h004, 32'h1);

      // unmask, W1C, write-0 no-op
      wr(12'h008, 32'h1);
      chk("t3_intr_on", 32'(Intr), 32'h0);
      wr(12'h004, 32'h1);
      chk("t3_intr_off", 32'(Intr), 32'h1);
      rdc("t3_status_clr", 12'h004, 32'h0);
      wr(12'h004, 32'h0);
      rdc("t3_status_w0", 12'h004, 32'h0);

      // event on ch2 coinciding with a W1C of the same bit
      pin_in[2] = 1'b0;
      for (int j = 0; j < D + 3; j++) tick();
      rdc("t4_fall_ignored", 12'h004, 32'h0);
      pin_in[2] = 1'b1;
      for (int j = 0; j < D + 1; j++) tick();
      wr(12'h004, 32'h4);
      rdc("t4_set_wins", 12'h004, 32'h4);
      wr(12'h004, 32'h4);
      rdc("t4_cleared", 12'h004, 32'h0);

      // both edges on ch1: press and release each captured
      wr(12'h010, 32'hF);
      pin_in[1] = 1'b0;
      for (int j = 0; j < D + 3; j++) tick();
      rdc("t4_press", 12'h004, 32'h2);
      wr(12'h004, 32'h2);
      pin_in[1] = 1'b1;
      for (int j = 0; j < D + 3; j++) tick();
      rdc("t4_release", 12'h004, 32'h2);
      wr(12'h004, 32'h2);

      // simultaneous read and write returns the pre-write value
      CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b0;
      Addr = 12'h008; DataIn = 32'hF;
      #1;
      chk("rdwr_old", DataOut, 32'h1);
      tick();
      bus_idle();
      rdc("rdwr_new", 12'h008, 32'hF);

      // async reset with ch0 mid-count
      pin_in[0] = 1'b1;
      for (int j = 0; j < 4; j++) tick();
      chk("t5_pre", 32'(level_out[0]), 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_level", 32'(level_out), 32'hF);
      chk("t5_async_intr", 32'(Intr), 32'h1);
      model_reset();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      rdc("t5_status", 12'h004, 32'h0);
      for (int j = 0; j < 2 * D; j++) begin
         tick();
         chk("t5_no_event", 32'(Intr), 32'h1);
      end
      rdc("t5_status_late", 12'h004, 32'h0);
      rdc("t5_imask", 12'h008, 32'h0);

      // unimplemented bits and offsets
      wr(12'h008, 32'hFFFF_FFFF);
      rdc("t6_imask_hi", 12'h008, 32'hF);
      rdc("t6_level_hi", 12'h000, 32'hF);
      wr(12'h000, 32'h0);
      rdc("t6_level_ro", 12'h000, 32'hF);
      wr(12'h100, 32'hFFFF_FFFF);
      rdc("t6_hole", 12'h100, 32'h0);
      CS_N = 1'b0; RD_N = 1'b1; WR_N = 1'b1; Addr = 12'h000;
      #1;
      chk("t6_no_rd", DataOut, 32'h0);
      bus_idle();
      tick();

      // random pins and bus traffic
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int it = 0; it < 500; it++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               pin_in[i] = 1'($urandom_range(0, 1));
               hold[i]   = int'($urandom_range(1, 3 * D));
            end else begin
               hold[i]--;
            end
         end
         op = int'($urandom_range(0, 9));
         a  = addrs[$urandom_range(0, 6)];
         d  = $urandom;
         CS_N   = (op == 9);
         RD_N   = !(op inside {0, 1, 2, 5});
         WR_N   = !(op inside {3, 4, 5});
         Addr   = a;
         DataIn = d;
         #1;
         chk("rnd_read", DataOut,
             (!CS_N && !RD_N) ? m_read(a) : 32'h0);
         tick();
      end
      bus_idle();
      for (int j = 0; j < 4 * D; j++) tick();
      rdc("rnd_final_status", 12'h004, m_read(12'h004));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
